// File: rtl/sample_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// sample_buffer_arbiter
//
// Purpose:
//   Shares one circular sample buffer between NREQ sampling units. A
//   round-robin arbiter accepts at most one producer write per cycle, and a
//   single consumer drains the buffer in order over a first-word fall-through
//   valid/ready port.
//
// Optional feature (macro BUF_SRC_TAG_EN):
//   When defined, every entry also stores the index of the requester that
//   wrote it. That index is presented on m_src for the entry at the read
//   pointer. m_src reads 0 while the buffer is empty.
//
// Ports:
//   clk      in   1               single clock, all logic on posedge
//   rst      in   1               synchronous active-high reset
//   s_valid  in   NREQ            per-requester sample valid
//   s_data   in   NREQ*DW         packed samples, requester i at [i*DW +: DW]
//   s_ready  out  NREQ            per-requester accept (one-hot or zero)
//   m_valid  out  1               buffer non-empty
//   m_data   out  DW              oldest sample (first-word fall-through)
//   m_ready  in   1               consumer pop
//   count    out  $clog2(DEPTH+1) current occupancy
//   full     out  1               count == DEPTH
//   empty    out  1               count == 0
//   m_src    out  $clog2(NREQ)    writer index of head entry (BUF_SRC_TAG_EN)
// -----------------------------------------------------------------------------
module sample_buffer_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              s_valid,
  input  logic [NREQ*DW-1:0]           s_data,
  output logic [NREQ-1:0]              s_ready,
  output logic                         m_valid,
  output logic [DW-1:0]                m_data,
  input  logic                         m_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
`ifdef BUF_SRC_TAG_EN
  ,
  output logic [$clog2(NREQ)-1:0]      m_src
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(NREQ);

  logic [DW-1:0] mem_q [DEPTH];
`ifdef BUF_SRC_TAG_EN
  logic [SW-1:0] tag_q [DEPTH];
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  logic          found_s;
  logic [SW-1:0] winner_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] win_data_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == CW'(0));

  // Round-robin search: first set s_valid bit at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = SW'(0);
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && s_valid[idx]) begin
        found_s  = 1'b1;
        winner_s = SW'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Handshakes are suppressed while reset is asserted so nothing completes
  // in a reset cycle. A full buffer refuses writes even when popping.
  assign push_s     = found_s & ~full_s & ~rst;
  assign pop_s      = ~empty_s & m_ready & ~rst;
  assign s_ready    = push_s ? (NREQ'(1) << winner_s) : NREQ'(0);
  assign win_data_s = s_data[int'(winner_s)*DW +: DW];

  assign m_valid = ~empty_s;
  assign m_data  = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_s;
  assign empty   = empty_s;
`ifdef BUF_SRC_TAG_EN
  assign m_src   = empty_s ? SW'(0) : tag_q[rd_ptr_q];
`endif

  // Next-state for pointers, occupancy and round-robin priority.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      // Priority moves just past the winner only when a write completes.
      if (winner_s == SW'(NREQ - 1)) begin
        rr_ptr_d = SW'(0);
      end else begin
        rr_ptr_d = winner_s + SW'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      rr_ptr_q <= SW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Buffer storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= win_data_s;
`ifdef BUF_SRC_TAG_EN
      tag_q[wr_ptr_q] <= winner_s;
`endif
    end
  end

endmodule

// File: tb/tb_sample_buffer_arbiter.sv
module tb_sample_buffer_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   s_valid;
  logic [NREQ*DW-1:0] s_data;
  logic [NREQ-1:0]   s_ready;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic              m_ready;
  logic [4:0]        count;
  logic              full;
  logic              empty;
`ifdef BUF_SRC_TAG_EN
  logic [1:0]        m_src;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO contents, writer tags, rotating priority, accept log.
  logic [DW-1:0] mq[$];
  int            sq[$];
  int            acc_log[$];
  int            rr_m = 0;

  always #5 clk = ~clk;

  sample_buffer_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .count   (count),
    .full    (full),
    .empty   (empty)
`ifdef BUF_SRC_TAG_EN
    ,
    .m_src   (m_src)
`endif
  );

  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT samples its inputs.
  always @(posedge clk) begin : model_upd
    int w;
    bit push, pop;
    if (rst) begin
      mq.delete();
      sq.delete();
      rr_m = 0;
    end else begin
      w    = pick(s_valid, rr_m);
      push = (w >= 0) && (mq.size() < DEPTH);
      pop  = (mq.size() > 0) && m_ready;
      if (pop) begin
        void'(mq.pop_front());
        void'(sq.pop_front());
      end
      if (push) begin
        mq.push_back(s_data[w*DW +: DW]);
        sq.push_back(w);
        acc_log.push_back(w);
        rr_m = (w + 1) % NREQ;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    int w;
    logic [NREQ-1:0] exp_rdy;
    if (chk_en) begin
      w = pick(s_valid, rr_m);
      exp_rdy = (!rst && w >= 0 && mq.size() < DEPTH) ? (4'b0001 << w) : 4'b0000;
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
`ifdef BUF_SRC_TAG_EN
      chk("m_src", 32'(m_src), (mq.size() > 0) ? 32'(sq[0]) : 32'd0);
`endif
    end
  end

  task automatic cyc(input logic r, input logic [NREQ-1:0] v,
                     input logic [31:0] d, input logic rd);
    rst = r; s_valid = v; s_data = d; m_ready = rd;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 4'b0000; s_data = 32'h0; m_ready = 1'b0;
    // 1. Reset for two cycles.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_m_valid", 32'(m_valid), 32'd0);
    chk("t1_s_ready", 32'(s_ready), 32'd0);

    // 2. Single requester 1 with 8'hA5.
    s_valid = 4'b0010; s_data = 32'h0000_A500; #1;
    chk("t2_s_ready", 32'(s_ready), 32'h2);
    @(posedge clk); #1;
    s_valid = 4'b0000;
    chk("t2_m_valid", 32'(m_valid), 32'd1);
    chk("t2_m_data", 32'(m_data), 32'hA5);
    chk("t2_count", 32'(count), 32'd1);
`ifdef BUF_SRC_TAG_EN
    chk("t2_m_src", 32'(m_src), 32'd1);
`endif
    cyc(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("t2_drain", 32'(count), 32'd0);

    // 3. Fairness with all requesters valid, from a fresh priority.
    cyc(1'b1, 4'b0000, 32'h0, 1'b0);
    cyc(1'b1, 4'b0000, 32'h0, 1'b0);
    acc_log.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'b1111, 32'h4342_4140, 1'b1);
      if (i == 0) chk("t3_first", 32'(m_data), 32'h40);
    end
    chk("t3_acc_n", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("t3_order", 32'(acc_log[i]), 32'(i % 4));
    end
    cyc(1'b0, 4'b0000, 32'h0, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("t3_drain", 32'(count), 32'd0);

    // 4. Fill to full, then a pop cycle with a pending writer.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 4'b0001, 32'(8'h10 + i), 1'b0);
    chk("t4_count16", 32'(count), 32'd16);
    chk("t4_full", 32'(full), 32'd1);
    s_valid = 4'b0001; s_data = 32'h99; m_ready = 1'b0; #1;
    chk("t4_s_ready_full", 32'(s_ready), 32'd0);
    m_ready = 1'b1; #1;
    chk("t4_s_ready_pop", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("t4_count15", 32'(count), 32'd15);
    m_ready = 1'b0; #1;
    chk("t4_s_ready_next", 32'(s_ready), 32'h1);
    @(posedge clk); #1;
    chk("t4_refill", 32'(count), 32'd16);
    chk("t4_full2", 32'(full), 32'd1);

    // 5. Wrap with simultaneous push and pop at count 5.
    cyc(1'b1, 4'b0000, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0100, {8'h00, 8'(8'h50 + i), 16'h0000}, 1'b0);
    chk("t5_pre", 32'(count), 32'd5);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 4'b0100, {8'h00, 8'(8'h60 + i), 16'h0000}, 1'b1);
      chk("t5_count", 32'(count), 32'd5);
    end
    chk("t5_head", 32'(m_data), 32'h83);

    // 6. Reset while holding 7 entries.
    for (int i = 0; i < 2; i++) cyc(1'b0, 4'b0100, {8'h00, 8'(8'hA0 + i), 16'h0000}, 1'b0);
    chk("t6_count7", 32'(count), 32'd7);
    cyc(1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1);
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    cyc(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("t6_underflow", 32'(count), 32'd0);
    chk("t6_empty2", 32'(empty), 32'd1);
    cyc(1'b0, 4'b0000, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
